// File: rtl/crc_frame_ctrl.sv
// Frame CRC sequencer: folds each accepted byte into an 8-bit LFSR, clocks it
// eight times bit-serially, and presents the frame CRC and byte count on a valid/ready port.
module crc_frame_ctrl #(
  parameter logic [7:0]  SEED  = 8'hFF,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  output logic             crc_valid_o,
  input  logic             crc_ready_i,
  output logic [7:0]       crc_o,
  output logic [LEN_W-1:0] crc_len_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       lfsr_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       cnt_q;
  logic             last_q;
  logic             in_ready_q;
  logic             crc_valid_q;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
    return (l == {LEN_W{1'b1}}) ? l : l + LEN_W'(1);
  endfunction

  // Handshake flags are registered alongside the state so they never depend on inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      len_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      crc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            lfsr_q     <= lfsr_q ^ in_data_i;
            cnt_q      <= '0;
            last_q     <= in_last_i;
            len_q      <= len_sat_inc(len_q);
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          lfsr_q <= lfsr_step(lfsr_q);
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (last_q) begin
              state_q     <= DONE;
              crc_valid_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (crc_ready_i) begin
            lfsr_q      <= SEED;
            len_q       <= '0;
            state_q     <= IDLE;
            crc_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          crc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign crc_valid_o = crc_valid_q;
  assign crc_o       = lfsr_q;
  assign crc_len_o   = len_q;
  // A frame counts as in progress between bytes too, since len is only cleared at the CRC handshake.
  assign busy_o      = (state_q != IDLE) || (len_q != '0);

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed and randomised checks of crc_frame_ctrl; a second instance uses SEED=00
// and a 2-bit length counter so reseed and length saturation can be observed.
module tb_crc_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        crc_ready;

  logic        ready_a, valid_a, busy_a;
  logic [7:0]  crc_a;
  logic [15:0] len_a;
  logic        ready_b, valid_b, busy_b;
  logic [7:0]  crc_b;
  logic [1:0]  len_b;

  int total;
  int bad;

  crc_frame_ctrl #(.SEED(8'hFF), .LEN_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(ready_a), .in_data_i(in_data), .in_last_i(in_last),
    .crc_valid_o(valid_a), .crc_ready_i(crc_ready), .crc_o(crc_a), .crc_len_o(len_a),
    .busy_o(busy_a)
  );

  crc_frame_ctrl #(.SEED(8'h00), .LEN_W(2)) dut_s0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(ready_b), .in_data_i(in_data), .in_last_i(in_last),
    .crc_valid_o(valid_b), .crc_ready_i(crc_ready), .crc_o(crc_b), .crc_len_o(len_b),
    .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] crc_byte(input logic [7:0] s, input logic [7:0] b);
    logic [7:0] x;
    x = s ^ b;
    for (int k = 0; k < 8; k++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ready_a && n < 100) begin tick(); n++; end
    if (!ready_a) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", ready_a);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!valid_a && n < 200) begin tick(); n++; end
    if (!valid_a) begin
      total++; bad++;
      $display("FAIL done_timeout crc_valid=%0b required=1", valid_a);
    end
  endtask

  task automatic pop();
    crc_ready = 1'b1;
    tick();
    crc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", ready_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", valid_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL rst_crc got=%h want=ff", crc_a); end
    total++; if (len_a !== 16'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", len_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_a); end
    total++; if (crc_b !== 8'h00) begin bad++; $display("FAIL rst_crc_s0 got=%h want=00", crc_b); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL t1_ready cyc=%0d got=%0b want=0", i, ready_a); end
      total++; if (valid_a !== (i == 9)) begin bad++; $display("FAIL t1_valid cyc=%0d got=%0b want=%0b", i, valid_a, (i == 9)); end
      if (i < 9) tick();
    end
    total++; if (crc_a !== 8'h0B) begin bad++; $display("FAIL t1_crc got=%h want=0b", crc_a); end
    total++; if (len_a !== 16'd1) begin bad++; $display("FAIL t1_len got=%0d want=1", len_a); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0b want=1", busy_a); end
    pop();
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL t1_ready_after got=%0b want=1", ready_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL t1_valid_after got=%0b want=0", valid_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL t1_busy_after got=%0b want=0", busy_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL t1_reseed got=%h want=ff", crc_a); end
  endtask

  task automatic test_seed_zero();
    send_byte(8'h01, 1'b1);
    wait_done();
    total++; if (crc_b !== 8'h1C) begin bad++; $display("FAIL s0_crc got=%h want=1c", crc_b); end
    total++; if (len_b !== 2'd1) begin bad++; $display("FAIL s0_len got=%0d want=1", len_b); end
    pop();
    send_byte(8'h00, 1'b1);
    wait_done();
    total++; if (crc_b !== 8'h00) begin bad++; $display("FAIL s0_reseed got=%h want=00", crc_b); end
    total++; if (crc_a !== 8'h0B) begin bad++; $display("FAIL s0_crc_ff got=%h want=0b", crc_a); end
    pop();
  endtask

  task automatic test_two_byte();
    int acc;
    int since;
    logic hs;
    acc = 0; since = 0;
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b0;
    for (int cyc = 0; cyc < 40 && !valid_a; cyc++) begin
      if (acc > 0 && since >= 1 && since <= 8) begin
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL t3_ready_low byte=%0d cyc=%0d got=%0b want=0", acc, since, ready_a); end
      end
      if (acc == 1 && since == 9) begin
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL t3_ready_high got=%0b want=1", ready_a); end
      end
      hs = ready_a && in_valid;
      tick();
      if (hs) begin
        acc++; since = 1; in_last = 1'b1;
        if (acc == 2) begin in_valid = 1'b0; in_last = 1'b0; end
      end else begin
        since++;
      end
    end
    in_valid = 1'b0;
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL t3_valid got=%0b want=1", valid_a); end
    total++; if (acc !== 2) begin bad++; $display("FAIL t3_consumed got=%0d want=2", acc); end
    total++; if (len_a !== 16'd2) begin bad++; $display("FAIL t3_len got=%0d want=2", len_a); end
    total++; if (crc_a !== 8'hC6) begin bad++; $display("FAIL t3_crc got=%h want=c6", crc_a); end
    pop();
  endtask

  task automatic test_backpressure();
    send_byte(8'h00, 1'b1);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", i, valid_a); end
      total++; if (crc_a !== 8'h0B) begin bad++; $display("FAIL bp_crc cyc=%0d got=%h want=0b", i, crc_a); end
      total++; if (len_a !== 16'd1) begin bad++; $display("FAIL bp_len cyc=%0d got=%0d want=1", i, len_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b want=0", i, ready_a); end
      tick();
    end
    pop();
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%0b want=1", ready_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%0b want=0", valid_a); end
  endtask

  task automatic test_clear();
    send_byte(8'hAA, 1'b0);
    tick(); tick(); tick();
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL clr_ready got=%0b want=1", ready_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL clr_crc got=%h want=ff", crc_a); end
    total++; if (len_a !== 16'd0) begin bad++; $display("FAIL clr_len got=%0d want=0", len_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0b want=0", busy_a); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clr_idle_busy got=%0b want=0", busy_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL clr_idle_crc got=%h want=ff", crc_a); end
    send_byte(8'h00, 1'b1);
    wait_done();
    total++; if (crc_a !== 8'h0B) begin bad++; $display("FAIL clr_crc_after got=%h want=0b", crc_a); end
    total++; if (len_a !== 16'd1) begin bad++; $display("FAIL clr_len_after got=%0d want=1", len_a); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL clr_done_valid got=%0b want=0", valid_a); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL clr_done_ready got=%0b want=1", ready_a); end
    total++; if (len_a !== 16'd0) begin bad++; $display("FAIL clr_done_len got=%0d want=0", len_a); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h00, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL rsh_ready got=%0b want=1", ready_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL rsh_crc got=%h want=ff", crc_a); end
    total++; if (len_a !== 16'd0) begin bad++; $display("FAIL rsh_len got=%0d want=0", len_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rsh_busy got=%0b want=0", busy_a); end
    send_byte(8'h00, 1'b1);
    wait_done();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rsd_valid got=%0b want=0", valid_a); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL rsd_ready got=%0b want=1", ready_a); end
    total++; if (crc_a !== 8'hFF) begin bad++; $display("FAIL rsd_crc got=%h want=ff", crc_a); end
    total++; if (len_a !== 16'd0) begin bad++; $display("FAIL rsd_len got=%0d want=0", len_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rsd_busy got=%0b want=0", busy_a); end
    send_byte(8'h00, 1'b1);
    wait_done();
    total++; if (crc_a !== 8'h0B) begin bad++; $display("FAIL rs_repeat_crc got=%h want=0b", crc_a); end
    total++; if (len_a !== 16'd1) begin bad++; $display("FAIL rs_repeat_len got=%0d want=1", len_a); end
    pop();
  endtask

  task automatic test_saturate();
    logic [7:0] bytes [5];
    logic [7:0] ea, eb;
    bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    ea = 8'hFF; eb = 8'h00;
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], i == 4);
      ea = crc_byte(ea, bytes[i]);
      eb = crc_byte(eb, bytes[i]);
    end
    wait_done();
    total++; if (len_b !== 2'd3) begin bad++; $display("FAIL sat_len got=%0d want=3", len_b); end
    total++; if (crc_b !== eb) begin bad++; $display("FAIL sat_crc got=%h want=%h", crc_b, eb); end
    total++; if (len_a !== 16'd5) begin bad++; $display("FAIL sat_len_wide got=%0d want=5", len_a); end
    total++; if (crc_a !== ea) begin bad++; $display("FAIL sat_crc_wide got=%h want=%h", crc_a, ea); end
    pop();
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b, ea, eb;
    logic [1:0] lb;
    for (int f = 0; f < 120; f++) begin
      n = $urandom_range(1, 12);
      ea = 8'hFF; eb = 8'h00;
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        b = 8'($urandom);
        send_byte(b, j == n - 1);
        ea = crc_byte(ea, b);
        eb = crc_byte(eb, b);
      end
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
      lb = (n > 3) ? 2'd3 : 2'(n);
      total++; if (crc_a !== ea) begin bad++; $display("FAIL rnd_crc frame=%0d got=%h want=%h", f, crc_a, ea); end
      total++; if (len_a !== 16'(n)) begin bad++; $display("FAIL rnd_len frame=%0d got=%0d want=%0d", f, len_a, n); end
      total++; if (crc_b !== eb) begin bad++; $display("FAIL rnd_crc_s0 frame=%0d got=%h want=%h", f, crc_b, eb); end
      total++; if (len_b !== lb) begin bad++; $display("FAIL rnd_len_s0 frame=%0d got=%0d want=%0d", f, len_b, lb); end
      pop();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; crc_ready = 1'b0;
    test_reset();
    test_single();
    test_seed_zero();
    test_two_byte();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
